linear_processing_element_wrapper: RTL and testbench



---
 rtl/linear_processing_element_wrapper.sv | 261 ++++++++++++++++++++++++++
 tb/tb_linear_processing_element_wrapper.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_processing_element_wrapper.sv
// One PE of a 2-D systolic MAC array: forwards operands right/down,
// accumulates aligned pairs and merges its result into the down psum stream.
// Ports: clk, rst; s_axis_l / m_axis_r (op0), s_axis_t / m_axis_b (op1),
//        s_axis_u / m_axis_d (psum), err_unalligned_data (sticky).

module lpe_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         free_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  logic [W-1:0] out_q, sk_q;
  logic         out_v_q, sk_v_q;

  // push is only issued while the skid slot is free
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= '0;
      sk_q    <= '0;
      out_v_q <= 1'b0;
      sk_v_q  <= 1'b0;
    end else if (!out_v_q || ready_i) begin
      if (sk_v_q) begin
        out_q   <= sk_q;
        out_v_q <= 1'b1;
        sk_v_q  <= 1'b0;
      end else begin
        out_v_q <= push_i;
        if (push_i) out_q <= data_i;
      end
    end else if (push_i) begin
      sk_q   <= data_i;
      sk_v_q <= 1'b1;
    end
  end

  assign free_o  = !sk_v_q;
  assign valid_o = out_v_q;
  assign data_o  = out_q;
endmodule

module linear_processing_element_wrapper #(
  parameter int PE_NUMBER_I         = 1,
  parameter int PE_NUMBER_J         = 3,
  parameter int PE_POSITION_I       = 0,
  parameter int PE_POSITION_J       = 1,
  parameter int DATA_WIDTH_OP0      = 16,
  parameter int FRACTIONAL_BITS_OP0 = 13,
  parameter int IS_UNSIGNED_OP0     = 0,
  parameter int DATA_WIDTH_OP1      = 16,
  parameter int FRACTIONAL_BITS_OP1 = 15,
  parameter int IS_UNSIGNED_OP1     = 0,
  parameter int DATA_WIDTH_PSUM     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH_OP0-1:0]  s_axis_l_tdata,
  input  logic                       s_axis_l_tvalid,
  input  logic                       s_axis_l_tlast,
  output logic                       s_axis_l_tready,
  output logic [DATA_WIDTH_OP0-1:0]  m_axis_r_tdata,
  output logic                       m_axis_r_tvalid,
  output logic                       m_axis_r_tlast,
  input  logic                       m_axis_r_tready,
  input  logic [DATA_WIDTH_OP1-1:0]  s_axis_t_tdata,
  input  logic                       s_axis_t_tvalid,
  input  logic                       s_axis_t_tlast,
  output logic                       s_axis_t_tready,
  output logic [DATA_WIDTH_OP1-1:0]  m_axis_b_tdata,
  output logic                       m_axis_b_tvalid,
  output logic                       m_axis_b_tlast,
  input  logic                       m_axis_b_tready,
  input  logic [DATA_WIDTH_PSUM-1:0] s_axis_u_tdata,
  input  logic                       s_axis_u_tvalid,
  input  logic                       s_axis_u_tlast,
  output logic                       s_axis_u_tready,
  output logic [DATA_WIDTH_PSUM-1:0] m_axis_d_tdata,
  output logic                       m_axis_d_tvalid,
  output logic                       m_axis_d_tlast,
  input  logic                       m_axis_d_tready,
  output logic                       err_unalligned_data
);
  localparam int W0  = DATA_WIDTH_OP0;
  localparam int W1  = DATA_WIDTH_OP1;
  localparam int PSW = DATA_WIDTH_PSUM;
  localparam int PW  = W0 + W1;
  localparam int SW  = ((PW + 2 > PSW) ? PW + 2 : PSW) + 1;
  localparam bit UNS = (IS_UNSIGNED_OP0 != 0) && (IS_UNSIGNED_OP1 != 0);
  localparam int FRAC_PSUM = FRACTIONAL_BITS_OP0 + FRACTIONAL_BITS_OP1;
  localparam bit CFG_OK = (PE_POSITION_I < PE_NUMBER_I)
                       && (PE_POSITION_J < PE_NUMBER_J)
                       && (FRAC_PSUM <= PSW);

  localparam logic signed [SW-1:0] HI = UNS
    ? {{(SW-PSW){1'b0}}, {PSW{1'b1}}}
    : {{(SW-PSW+1){1'b0}}, {(PSW-1){1'b1}}};
  localparam logic signed [SW-1:0] LO = UNS
    ? '0
    : {{(SW-PSW+1){1'b1}}, {(PSW-1){1'b0}}};

  if (!CFG_OK) begin : g_bad_cfg
    $error("PE position or psum fractional width out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_FWD_U, S_OWN} st_e;

  logic               run_q;
  logic               r_free, b_free, hold, can_acc, acc_en, misal;
  logic [W0:0]        r_pl;
  logic [W1:0]        b_pl;
  logic signed [W0:0] a_x;
  logic signed [W1:0] b_x;
  logic signed [PW+1:0] prod, p_q;
  logic               p_v_q, p_end_q, p_mis_q;
  logic [PSW-1:0]     acc_q, acc_d, res_q;
  logic               res_v_q, err_q;
  logic signed [SW-1:0] acc_x, p_x, sum;
  st_e                st_q, st_d;
  logic               last_u_q, u_end, own_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  // a result waiting on a full result register freezes the multiplier
  assign hold    = p_v_q & p_end_q & res_v_q;
  assign can_acc = run_q & r_free & b_free & !hold;
  assign s_axis_l_tready = can_acc;
  assign s_axis_t_tready = can_acc;
  assign acc_en = can_acc & s_axis_l_tvalid & s_axis_t_tvalid;
  assign misal  = s_axis_l_tlast ^ s_axis_t_tlast;

  lpe_skid #(.W(W0+1)) u_fwd_r (
    .clk_i(clk), .rst_i(rst), .push_i(acc_en),
    .data_i({s_axis_l_tlast, s_axis_l_tdata}), .free_o(r_free),
    .valid_o(m_axis_r_tvalid), .ready_i(m_axis_r_tready), .data_o(r_pl)
  );
  assign {m_axis_r_tlast, m_axis_r_tdata} = r_pl;

  lpe_skid #(.W(W1+1)) u_fwd_b (
    .clk_i(clk), .rst_i(rst), .push_i(acc_en),
    .data_i({s_axis_t_tlast, s_axis_t_tdata}), .free_o(b_free),
    .valid_o(m_axis_b_tvalid), .ready_i(m_axis_b_tready), .data_o(b_pl)
  );
  assign {m_axis_b_tlast, m_axis_b_tdata} = b_pl;

  // one extra bit per operand lets signed/unsigned mixes share one multiplier
  assign a_x = (IS_UNSIGNED_OP0 != 0) ? {1'b0, s_axis_l_tdata}
             : {s_axis_l_tdata[W0-1], s_axis_l_tdata};
  assign b_x = (IS_UNSIGNED_OP1 != 0) ? {1'b0, s_axis_t_tdata}
             : {s_axis_t_tdata[W1-1], s_axis_t_tdata};
  assign prod = a_x * b_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      p_v_q   <= 1'b0;
      p_end_q <= 1'b0;
      p_mis_q <= 1'b0;
    end else if (!hold) begin
      p_q     <= prod;
      p_v_q   <= acc_en;
      p_end_q <= s_axis_l_tlast & s_axis_t_tlast;
      p_mis_q <= misal;
    end
  end

  assign acc_x = UNS ? {{(SW-PSW){1'b0}}, acc_q}
               : {{(SW-PSW){acc_q[PSW-1]}}, acc_q};
  assign p_x = {{(SW-PW-2){p_q[PW+1]}}, p_q};

  always_comb begin
    sum   = acc_x + p_x;
    acc_d = sum[PSW-1:0];
    if (sum > HI)      acc_d = HI[PSW-1:0];
    else if (sum < LO) acc_d = LO[PSW-1:0];
  end

  assign own_done = (st_q == S_OWN) & m_axis_d_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      res_q   <= '0;
      res_v_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (acc_en & misal) err_q <= 1'b1;
      if (own_done) res_v_q <= 1'b0;
      if (p_v_q & !hold) begin
        if (p_mis_q) begin
          acc_q <= '0;
        end else if (p_end_q) begin
          res_q   <= acc_d;
          res_v_q <= 1'b1;
          acc_q   <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  end

  assign err_unalligned_data = err_q;

  assign u_end = (st_q == S_FWD_U) & s_axis_u_tvalid
               & m_axis_d_tready & s_axis_u_tlast;

  // last_u_q gives the own result its turn after a u packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= S_IDLE;
      last_u_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (u_end)         last_u_q <= 1'b1;
      else if (own_done) last_u_q <= 1'b0;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: begin
        if (s_axis_u_tvalid && !(res_v_q && last_u_q)) st_d = S_FWD_U;
        else if (res_v_q)                              st_d = S_OWN;
      end
      S_FWD_U: if (u_end)           st_d = S_IDLE;
      S_OWN:   if (m_axis_d_tready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_axis_d_tdata  = '0;
    m_axis_d_tvalid = 1'b0;
    m_axis_d_tlast  = 1'b0;
    s_axis_u_tready = 1'b0;
    unique case (st_q)
      S_FWD_U: begin
        m_axis_d_tdata  = s_axis_u_tdata;
        m_axis_d_tvalid = s_axis_u_tvalid;
        m_axis_d_tlast  = s_axis_u_tlast;
        s_axis_u_tready = m_axis_d_tready;
      end
      S_OWN: begin
        m_axis_d_tdata  = res_q;
        m_axis_d_tvalid = 1'b1;
        m_axis_d_tlast  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_linear_processing_element_wrapper.sv
// Scoreboard bench for linear_processing_element_wrapper.
// Forwarded beats, psum results and u pass-through are checked in order.

module tb_linear_processing_element_wrapper;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] s_axis_l_tdata, m_axis_r_tdata;
  logic        s_axis_l_tvalid, s_axis_l_tlast, s_axis_l_tready;
  logic        m_axis_r_tvalid, m_axis_r_tlast, m_axis_r_tready;
  logic [15:0] s_axis_t_tdata, m_axis_b_tdata;
  logic        s_axis_t_tvalid, s_axis_t_tlast, s_axis_t_tready;
  logic        m_axis_b_tvalid, m_axis_b_tlast, m_axis_b_tready;
  logic [31:0] s_axis_u_tdata, m_axis_d_tdata;
  logic        s_axis_u_tvalid, s_axis_u_tlast, s_axis_u_tready;
  logic        m_axis_d_tvalid, m_axis_d_tlast, m_axis_d_tready;
  logic        err_unalligned_data;

  linear_processing_element_wrapper dut (
    .clk(clk), .rst(rst),
    .s_axis_l_tdata(s_axis_l_tdata), .s_axis_l_tvalid(s_axis_l_tvalid),
    .s_axis_l_tlast(s_axis_l_tlast), .s_axis_l_tready(s_axis_l_tready),
    .m_axis_r_tdata(m_axis_r_tdata), .m_axis_r_tvalid(m_axis_r_tvalid),
    .m_axis_r_tlast(m_axis_r_tlast), .m_axis_r_tready(m_axis_r_tready),
    .s_axis_t_tdata(s_axis_t_tdata), .s_axis_t_tvalid(s_axis_t_tvalid),
    .s_axis_t_tlast(s_axis_t_tlast), .s_axis_t_tready(s_axis_t_tready),
    .m_axis_b_tdata(m_axis_b_tdata), .m_axis_b_tvalid(m_axis_b_tvalid),
    .m_axis_b_tlast(m_axis_b_tlast), .m_axis_b_tready(m_axis_b_tready),
    .s_axis_u_tdata(s_axis_u_tdata), .s_axis_u_tvalid(s_axis_u_tvalid),
    .s_axis_u_tlast(s_axis_u_tlast), .s_axis_u_tready(s_axis_u_tready),
    .m_axis_d_tdata(m_axis_d_tdata), .m_axis_d_tvalid(m_axis_d_tvalid),
    .m_axis_d_tlast(m_axis_d_tlast), .m_axis_d_tready(m_axis_d_tready),
    .err_unalligned_data(err_unalligned_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  logic [16:0] qr[$], qb[$];
  logic [32:0] qu[$], qown[$];
  longint      macc;
  bit          merr, lat_chk, prev_acc, merge_mode, pv;
  int          u_cnt;
  logic [32:0] pd;

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      logic acc, u_hs;
      longint p;
      acc  = s_axis_l_tvalid & s_axis_t_tvalid & s_axis_l_tready;
      u_hs = s_axis_u_tvalid & s_axis_u_tready;
      chk("rdy_eq", s_axis_l_tready, s_axis_t_tready);
      chk("err", err_unalligned_data, merr);
      if (lat_chk && prev_acc) chk("r_lat", m_axis_r_tvalid, 1);
      prev_acc = acc & (m_axis_r_tready | !m_axis_r_tvalid);
      if (pv) begin
        chk("d_hold_v", m_axis_d_tvalid, 1);
        chk("d_hold", {m_axis_d_tlast, m_axis_d_tdata}, pd);
      end
      pv = m_axis_d_tvalid & !m_axis_d_tready;
      pd = {m_axis_d_tlast, m_axis_d_tdata};
      if (acc) begin
        qr.push_back({s_axis_l_tlast, s_axis_l_tdata});
        qb.push_back({s_axis_t_tlast, s_axis_t_tdata});
        p = longint'($signed(s_axis_l_tdata))
          * longint'($signed(s_axis_t_tdata));
        if (s_axis_l_tlast != s_axis_t_tlast) begin
          merr = 1'b1;
          macc = 0;
        end else begin
          macc = sat32(macc + p);
          if (s_axis_l_tlast) begin
            qown.push_back({1'b1, macc[31:0]});
            macc = 0;
          end
        end
      end
      if (m_axis_r_tvalid && m_axis_r_tready) begin
        if (qr.size() == 0) chk("r_extra", 1, 0);
        else chk("r", {m_axis_r_tlast, m_axis_r_tdata}, qr.pop_front());
      end
      if (m_axis_b_tvalid && m_axis_b_tready) begin
        if (qb.size() == 0) chk("b_extra", 1, 0);
        else chk("b", {m_axis_b_tlast, m_axis_b_tdata}, qb.pop_front());
      end
      if (u_hs) begin
        qu.push_back({s_axis_u_tlast, s_axis_u_tdata});
        u_cnt++;
      end
      if (m_axis_d_tvalid && m_axis_d_tready) begin
        if (u_hs) begin
          chk("d_u", {m_axis_d_tlast, m_axis_d_tdata}, qu.pop_front());
        end else if (qown.size() == 0) begin
          chk("d_extra", 1, 0);
        end else begin
          chk("d_own", {m_axis_d_tlast, m_axis_d_tdata}, qown.pop_front());
          if (merge_mode) chk("merge_order", u_cnt, 6);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    qr.delete(); qb.delete(); qu.delete(); qown.delete();
    macc = 0; merr = 1'b0; prev_acc = 1'b0; pv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rv", m_axis_r_tvalid, 0);
    chk("rst_bv", m_axis_b_tvalid, 0);
    chk("rst_dv", {m_axis_d_tvalid, m_axis_d_tlast, m_axis_d_tdata}, 0);
    chk("rst_rdy", {s_axis_l_tready, s_axis_t_tready, s_axis_u_tready}, 0);
    chk("rst_err", err_unalligned_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pair(input logic [15:0] l, input logic [15:0] t,
                      input logic ll, input logic tl);
    int k;
    s_axis_l_tdata = l; s_axis_l_tlast = ll; s_axis_l_tvalid = 1'b1;
    s_axis_t_tdata = t; s_axis_t_tlast = tl; s_axis_t_tvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!s_axis_l_tready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("pair_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic pair_idle();
    s_axis_l_tvalid = 1'b0;
    s_axis_t_tvalid = 1'b0;
    s_axis_l_tlast  = 1'b0;
    s_axis_t_tlast  = 1'b0;
  endtask

  task automatic send_u(input logic [31:0] d, input logic last);
    int k;
    s_axis_u_tdata = d; s_axis_u_tlast = last; s_axis_u_tvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!s_axis_u_tready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("u_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((qr.size() + qb.size() + qu.size() + qown.size()) != 0
           && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (k >= 500) chk("drain_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    s_axis_l_tdata = '0; s_axis_t_tdata = '0; s_axis_u_tdata = '0;
    s_axis_u_tvalid = 1'b0; s_axis_u_tlast = 1'b0;
    pair_idle();
    m_axis_r_tready = 1'b1; m_axis_b_tready = 1'b1; m_axis_d_tready = 1'b1;
    lat_chk = 1'b0; merge_mode = 1'b0; u_cnt = 0;
    do_reset();

    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) pair(16'h1000, 16'hF000, i == 4, i == 4);
    pair_idle();
    drain();
    lat_chk = 1'b0;

    pair(16'hF000, 16'hF000, 1'b0, 1'b0);
    pair(16'hF000, 16'hF000, 1'b0, 1'b0);
    pair(16'h8000, 16'h8000, 1'b1, 1'b1);
    pair_idle();
    drain();

    for (int i = 0; i < 8; i++) pair(16'h8000, 16'h8000, i == 7, i == 7);
    pair_idle();
    drain();

    for (int i = 1; i <= 24; i++)
      pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           i == 22, i == 24);
    pair_idle();
    drain();
    chk("err_sticky", err_unalligned_data, 1);
    do_reset();
    chk("err_cleared", err_unalligned_data, 0);

    merge_mode = 1'b1;
    u_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_u((i % 2 == 0) ? 32'd1 : 32'hFFFF_FFFF, i == 5);
        s_axis_u_tvalid = 1'b0;
        s_axis_u_tlast  = 1'b0;
      end
      begin
        @(posedge clk); #1;
        pair(16'hF000, 16'hF000, 1'b0, 1'b0);
        pair(16'hF000, 16'hF000, 1'b0, 1'b0);
        pair(16'h8000, 16'h8000, 1'b1, 1'b1);
        pair_idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1 m_axis_d_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_axis_d_tready = 1'b1;
      end
    join
    drain();
    merge_mode = 1'b0;

    fork
      begin
        for (int i = 0; i < 10; i++)
          pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               i == 9, i == 9);
        pair_idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_axis_r_tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_l_rdy", s_axis_l_tready, 0);
        chk("bp_t_rdy", s_axis_t_tready, 0);
        repeat (2) @(posedge clk);
        #1 m_axis_r_tready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) pair(16'h4000, 16'h4000, 1'b0, 1'b0);
    pair_idle();
    do_reset();
    pair(16'h0123, 16'hFF00, 1'b0, 1'b0);
    pair(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    pair_idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
